alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: Clock in 1 (rising edge); clear in 1 (asynchronous, active-low; 0 = reset).
REQ-002 SHALL have these inputs:
- start  in  1  request to run one instruction.
- mem_ready  in  1  memory read complete.
- IR  in  32  datapath IR contents.
REQ-003 SHALL have these datapath-strobe outputs, each 1 bit: PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin, Yin, IncPC, Read, Zin_low, Zin_high, HIin, LOin.
REQ-004 SHALL have these register and ALU outputs:
- Rout  out  16  one-hot register-out select.
- Rin  out  16  one-hot register-in select.
- operation  out  4  ALU op.
REQ-005 SHALL have these status outputs:
- busy  out  1  instruction in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle illegal-opcode pulse.
- instr_count  out  16  completed instructions.

Function
REQ-006 SHALL implement states IDLE, T0, T1, T2, T3, T4, T5, T6; each state lasts one cycle unless stated otherwise.
REQ-007 IDLE: SHALL go to T0 when start=1, else stay; busy=0 only in IDLE.
REQ-008 T0: SHALL assert PCout, MARin, IncPC, Zin_low; next state T1.
REQ-009 T1: SHALL assert Zlowout, Read, MDRin and hold while mem_ready=0; PCin=1 only on the cycle mem_ready=1; next state T2 on that cycle.
REQ-010 T2: SHALL assert MDRout, IRin; next state T3.
REQ-011 T3: SHALL latch fields opcode=IR[31:27], Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15]; SHALL assert Rout[Rb], Yin; next state T4.
REQ-012 An illegal opcode in T3 SHALL assert no Yin or Rout, pulse err, and return to IDLE; no register write and no instr_count change.
REQ-013 Opcode-to-operation map: 00011 add->0000, 00100 sub->0001, 00101 and->0010, 00110 or->0011, 00111 shr->0100, 01000 shl->0101, 01001 ror->0110, 01010 rol->0111; all others illegal.
REQ-014 T4: SHALL assert Rout[Rc], Zin_low and drive operation; next state T5.
REQ-015 operation SHALL be 0000 in every state except T4.
REQ-016 T5: SHALL assert Zlowout, Rin[Ra], done; Ra=0 is writable.
REQ-017 From the completing state, SHALL go to T0 if start=1 (back-to-back), else IDLE.
REQ-018 instr_count SHALL increment on each done pulse, wrapping 0xFFFF->0x0000.
REQ-019 All strobes SHALL be 0 in any state not listed as asserting them.
REQ-020 Rout and Rin SHALL be one-hot or zero.

Reset
REQ-021 clear=0 SHALL immediately force state IDLE, all outputs 0, and instr_count=0, including mid-instruction.
REQ-022 After clear rises, the first start SHALL be honoured on the next rising Clock edge.

Configuration
REQ-023 Macro ALU_SEQ_MULDIV_EN SHALL gate multiply/divide support.
REQ-024 Defined: opcode 01111 mul->1000 and 10000 div->1001 are legal.
- T4 additionally asserts Zin_high.
- T5 asserts Zlowout and LOin instead of Rin, with no done.
- T6 asserts Zhighout, HIin, done, then follows REQ-017.
REQ-025 Undefined: 01111 and 10000 are illegal per REQ-012; T6 is unreachable; HIin, LOin, Zin_high, Zhighout are tied 0.

Verification
REQ-026 Preload R2=0x12, R3=0x14; IR=0x28918000, start pulse, mem_ready=1 -> T3 Rout=0x0004; T4 Rout=0x0008, operation=0010; T5 Rin=0x0002; R1=0x10; done once; instr_count=1.
REQ-027 mem_ready held 0 for 3 cycles in T1 -> Read/MDRin high for 4 cycles; PCin high exactly one cycle; PC advances by 1 only.
REQ-028 IR opcode 11111 -> err pulse after T3; no Rin asserted; instr_count unchanged; busy=0 next cycle.
REQ-029 start held 1 for two add instructions -> T5 followed directly by T0; two done pulses; instr_count=2.
REQ-030 clear=0 asserted during T4 -> outputs 0 within the same cycle; after release, state IDLE and instr_count=0.
REQ-031 With ALU_SEQ_MULDIV_EN defined, mul R2=0x10000 x R3=0x10000 -> T5 LOin, T6 HIin; LO=0x0, HI=0x1; done only in T6.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer -- control sequencer for a simple bus-based datapath.
//
// Walks one instruction through fetch (T0-T2), operand set-up (T3),
// ALU execute (T4) and write-back (T5, plus T6 for mul/div), driving
// the datapath strobes as combinational decodes of the current state.
// Strobes are pure functions of state (plus mem_ready / IR where noted),
// so the asynchronous clear drives every output to 0 the moment it falls.
//
// Ports:
//   Clock        rising-edge clock
//   clear        asynchronous active-low reset
//   start        request to run one instruction
//   mem_ready    memory read complete (ends the T1 wait)
//   IR[31:0]     datapath IR; opcode=[31:27] Ra=[26:23] Rb=[22:19] Rc=[18:15]
//   PCout..LOin  one-bit datapath strobes
//   Rout/Rin     one-hot register read / write selects
//   operation    ALU op code, non-zero only in T4
//   busy         high whenever not IDLE
//   done / err   one-cycle completion / illegal-opcode pulses
//   instr_count  completed instruction counter (wraps)
//
// Build option: define ALU_SEQ_MULDIV_EN to enable mul (01111) and
// div (10000). Without it those opcodes are illegal, T6 is unreachable
// and Zin_high, Zhighout, LOin, HIin stay 0.
module alu_sequencer (
  input  logic        Clock,
  input  logic        clear,
  input  logic        start,
  input  logic        mem_ready,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        MDRout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        IncPC,
  output logic        Read,
  output logic        Zin_low,
  output logic        Zin_high,
  output logic        HIin,
  output logic        LOin,
  output logic [15:0] Rout,
  output logic [15:0] Rin,
  output logic [3:0]  operation,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] instr_count
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] T0   = 3'd1;
  localparam logic [2:0] T1   = 3'd2;
  localparam logic [2:0] T2   = 3'd3;
  localparam logic [2:0] T3   = 3'd4;
  localparam logic [2:0] T4   = 3'd5;
  localparam logic [2:0] T5   = 3'd6;
  localparam logic [2:0] T6   = 3'd7;

  // Returns {legal, operation}.
  function automatic logic [4:0] decode_op(input logic [4:0] opc);
    case (opc)
      5'b00011: return {1'b1, 4'b0000};
      5'b00100: return {1'b1, 4'b0001};
      5'b00101: return {1'b1, 4'b0010};
      5'b00110: return {1'b1, 4'b0011};
      5'b00111: return {1'b1, 4'b0100};
      5'b01000: return {1'b1, 4'b0101};
      5'b01001: return {1'b1, 4'b0110};
      5'b01010: return {1'b1, 4'b0111};
`ifdef ALU_SEQ_MULDIV_EN
      5'b01111: return {1'b1, 4'b1000};
      5'b10000: return {1'b1, 4'b1001};
`endif
      default:  return 5'b0_0000;
    endcase
  endfunction

  logic [2:0]  state_reg, state_next;
  logic [4:0]  opcode_reg;
  logic [3:0]  ra_reg;
  logic [3:0]  rc_reg;
  logic [15:0] count_reg;

  logic [4:0]  ir_dec;
  logic [4:0]  lat_dec;
  logic        unused_bits;

  assign ir_dec      = decode_op(IR[31:27]);
  assign lat_dec     = decode_op(opcode_reg);
  assign unused_bits = ^{IR[14:0], lat_dec[4]};
  assign busy        = (state_reg != IDLE);
  assign instr_count = count_reg;

`ifdef ALU_SEQ_MULDIV_EN
  // mul/div are the only ops with bit 3 set; they write LO/HI, not Rin.
  logic lat_muldiv;
  assign lat_muldiv = lat_dec[3];
`endif

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state_reg  <= IDLE;
      opcode_reg <= 5'd0;
      ra_reg     <= 4'd0;
      rc_reg     <= 4'd0;
      count_reg  <= 16'd0;
    end else begin
      state_reg <= state_next;
      if (state_reg == T3) begin
        opcode_reg <= IR[31:27];
        ra_reg     <= IR[26:23];
        rc_reg     <= IR[18:15];
      end
      if (done) begin
        count_reg <= count_reg + 16'd1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    PCout      = 1'b0;
    Zlowout    = 1'b0;
    Zhighout   = 1'b0;
    MDRout     = 1'b0;
    MARin      = 1'b0;
    PCin       = 1'b0;
    MDRin      = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    IncPC      = 1'b0;
    Read       = 1'b0;
    Zin_low    = 1'b0;
    Zin_high   = 1'b0;
    HIin       = 1'b0;
    LOin       = 1'b0;
    Rout       = 16'd0;
    Rin        = 16'd0;
    operation  = 4'd0;
    done       = 1'b0;
    err        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = T0;
      end
      T0: begin
        PCout      = 1'b1;
        MARin      = 1'b1;
        IncPC      = 1'b1;
        Zin_low    = 1'b1;
        state_next = T1;
      end
      T1: begin
        // Z already holds PC+1; it is copied to PC only on the completing cycle.
        Zlowout = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        if (mem_ready) begin
          PCin       = 1'b1;
          state_next = T2;
        end
      end
      T2: begin
        MDRout     = 1'b1;
        IRin       = 1'b1;
        state_next = T3;
      end
      T3: begin
        // IR was loaded at the end of T2, so decode straight from the port.
        if (ir_dec[4]) begin
          Rout       = 16'd1 << IR[22:19];
          Yin        = 1'b1;
          state_next = T4;
        end else begin
          err        = 1'b1;
          state_next = IDLE;
        end
      end
      T4: begin
        Rout       = 16'd1 << rc_reg;
        Zin_low    = 1'b1;
        operation  = lat_dec[3:0];
`ifdef ALU_SEQ_MULDIV_EN
        Zin_high   = lat_muldiv;
`endif
        state_next = T5;
      end
      T5: begin
        Zlowout = 1'b1;
`ifdef ALU_SEQ_MULDIV_EN
        if (lat_muldiv) begin
          LOin       = 1'b1;
          state_next = T6;
        end else begin
          Rin        = 16'd1 << ra_reg;
          done       = 1'b1;
          state_next = start ? T0 : IDLE;
        end
`else
        Rin        = 16'd1 << ra_reg;
        done       = 1'b1;
        state_next = start ? T0 : IDLE;
`endif
      end
      T6: begin
`ifdef ALU_SEQ_MULDIV_EN
        Zhighout   = 1'b1;
        HIin       = 1'b1;
        done       = 1'b1;
        state_next = start ? T0 : IDLE;
`else
        state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: a small bus datapath model (PC, MAR, MDR,
// IR, Y, Z, LO/HI, 16-register file, instruction memory) reacts to the
// sequencer strobes; directed instruction vectors with hand-computed
// results are run through it, plus hand-written stall, back-to-back,
// mid-instruction reset and (when enabled) mul sequences.
module tb_alu_sequencer;

  logic        Clock = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic        mem_ready = 1'b0;
  logic [31:0] IR;
  logic        PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin;
  logic        Yin, IncPC, Read, Zin_low, Zin_high, HIin, LOin;
  logic [15:0] Rout, Rin;
  logic [3:0]  operation;
  logic        busy, done, err;
  logic [15:0] instr_count;

  alu_sequencer dut (
    .Clock(Clock), .clear(clear), .start(start), .mem_ready(mem_ready), .IR(IR),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .IncPC(IncPC), .Read(Read), .Zin_low(Zin_low), .Zin_high(Zin_high),
    .HIin(HIin), .LOin(LOin), .Rout(Rout), .Rin(Rin), .operation(operation),
    .busy(busy), .done(done), .err(err), .instr_count(instr_count)
  );

  always #5 Clock = ~Clock;

  // ---------------- datapath model ----------------
  logic [31:0] pc_m = 0, mar_m = 0, mdr_m = 0, ir_m = 0, y_m = 0;
  logic [31:0] zlo_m = 0, zhi_m = 0, lo_m = 0, hi_m = 0;
  logic [31:0] rf [16] = '{default: 32'd0};
  logic [31:0] mem [16];
  logic [31:0] bus;
  logic [63:0] alu;
  logic        pre_en = 1'b0;
  logic [3:0]  pre_a = 0, pre_b = 0;
  logic [31:0] pre_va = 0, pre_vb = 0;

  assign IR = ir_m;

  function automatic logic [63:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return {32'd0, a + b};
      4'd1: return {32'd0, a - b};
      4'd2: return {32'd0, a & b};
      4'd3: return {32'd0, a | b};
      4'd4: return {32'd0, a >> b[4:0]};
      4'd5: return {32'd0, a << b[4:0]};
      4'd6: return {32'd0, (a >> b[4:0]) | (a << (6'd32 - {1'b0, b[4:0]}))};
      4'd7: return {32'd0, (a << b[4:0]) | (a >> (6'd32 - {1'b0, b[4:0]}))};
      4'd8: return {32'd0, a} * {32'd0, b};
      4'd9: return (b == 0) ? 64'd0 : {a % b, a / b};
      default: return 64'd0;
    endcase
  endfunction

  always_comb begin
    bus = 32'd0;
    if (PCout) bus = pc_m;
    else if (Zlowout) bus = zlo_m;
    else if (Zhighout) bus = zhi_m;
    else if (MDRout) bus = mdr_m;
    else begin
      for (int i = 0; i < 16; i++) if (Rout[i]) bus = rf[i];
    end
  end

  assign alu = alu_f(operation, y_m, bus);

  always @(posedge Clock) begin
    if (pre_en) begin
      rf[pre_a] <= pre_va;
      rf[pre_b] <= pre_vb;
    end
    if (MARin) mar_m <= bus;
    if (Zin_low) zlo_m <= IncPC ? bus + 32'd1 : alu[31:0];
    if (Zin_high) zhi_m <= alu[63:32];
    if (PCin) pc_m <= bus;
    if (MDRin && Read && mem_ready) mdr_m <= mem[mar_m[3:0]];
    if (IRin) ir_m <= bus;
    if (Yin) y_m <= bus;
    for (int i = 0; i < 16; i++) if (Rin[i]) rf[i] <= bus;
    if (LOin) lo_m <= bus;
    if (HIin) hi_m <= bus;
  end

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_bad = 0;
  int exp_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'd0};
  endfunction

  // observations from the last run
  int n_read, n_pcin, n_done, n_err, n_lo, n_hi, n_b2b, n_viol, n_done_hi;
  logic [15:0] rout_t3, rout_t4, rin_t5;
  logic [3:0]  op_t4;
  logic        finished;

  task automatic preload(input logic [3:0] a, input logic [31:0] va, input logic [3:0] b, input logic [31:0] vb);
    pre_a = a; pre_va = va; pre_b = b; pre_vb = vb; pre_en = 1'b1;
    @(negedge Clock);
    pre_en = 1'b0;
  endtask

  // Runs n_instr instructions (start held for back-to-back), holding
  // mem_ready low for 'stall' cycles in the first T1.
  task automatic run(input int n_instr, input int stall);
    int   stall_left;
    logic prev_done;
    stall_left = stall; prev_done = 1'b0;
    n_read = 0; n_pcin = 0; n_done = 0; n_err = 0; n_lo = 0; n_hi = 0;
    n_b2b = 0; n_viol = 0; n_done_hi = 0;
    rout_t3 = 0; rout_t4 = 0; rin_t5 = 0; op_t4 = 0; finished = 1'b0;
    @(negedge Clock);
    start = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge Clock);
      if (Read) begin
        mem_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end else begin
        mem_ready = 1'b0;
      end
      #1;
      if (Read) n_read++;
      if (PCin) n_pcin++;
      if (Yin) rout_t3 = Rout;
      if (Zin_low && !IncPC) begin rout_t4 = Rout; op_t4 = operation; end
      if (Rin != 0) rin_t5 = Rin;
      if (LOin) n_lo++;
      if (HIin) n_hi++;
      if (done) n_done++;
      if (done && HIin) n_done_hi++;
      if (err) n_err++;
      if (operation != 0 && !(Zin_low && !IncPC)) n_viol++;
      if ((Rout & (Rout - 16'd1)) != 0 || (Rin & (Rin - 16'd1)) != 0) n_viol++;
      if (prev_done && PCout) n_b2b++;
      prev_done = done;
      if (n_done + n_err >= n_instr) begin finished = 1'b1; break; end
      if (n_done + n_err >= n_instr - 1 && !(done || err)) start = 1'b0;
    end
    start = 1'b0;
    check("run_completed", 32'(finished), 32'd1);
  endtask

  typedef struct {
    logic [4:0]  opc;
    logic [3:0]  ra, rb, rc;
    logic [31:0] vb, vc, res;
    logic [3:0]  op;
    logic        bad;
  } vec_t;

  vec_t tv [12];

  initial begin
    logic [31:0] pc0, old_ra;
    logic        hit;
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;

    tv[0]  = '{5'b00101, 4'd1,  4'd2,  4'd3,  32'h12,       32'h14, 32'h10,       4'd2, 1'b0};
    tv[1]  = '{5'b00011, 4'd4,  4'd5,  4'd6,  32'h1234,     32'h1111, 32'h2345,   4'd0, 1'b0};
    tv[2]  = '{5'b00100, 4'd7,  4'd8,  4'd9,  32'd5,        32'd7,  32'hFFFFFFFE, 4'd1, 1'b0};
    tv[3]  = '{5'b00110, 4'd0,  4'd10, 4'd11, 32'hF0,       32'h0F, 32'hFF,       4'd3, 1'b0};
    tv[4]  = '{5'b00111, 4'd12, 4'd13, 4'd14, 32'h80,       32'd3,  32'h10,       4'd4, 1'b0};
    tv[5]  = '{5'b01000, 4'd15, 4'd14, 4'd13, 32'h3,        32'd4,  32'h30,       4'd5, 1'b0};
    tv[6]  = '{5'b01001, 4'd1,  4'd2,  4'd3,  32'h1,        32'd1,  32'h80000000, 4'd6, 1'b0};
    tv[7]  = '{5'b01010, 4'd4,  4'd5,  4'd6,  32'h80000001, 32'd4,  32'h18,       4'd7, 1'b0};
    tv[8]  = '{5'b11111, 4'd9,  4'd2,  4'd3,  32'd1,        32'd2,  32'd0,        4'd0, 1'b1};
    tv[9]  = '{5'b00000, 4'd9,  4'd2,  4'd3,  32'd1,        32'd2,  32'd0,        4'd0, 1'b1};
    tv[10] = '{5'b01011, 4'd9,  4'd2,  4'd3,  32'd1,        32'd2,  32'd0,        4'd0, 1'b1};
`ifdef ALU_SEQ_MULDIV_EN
    tv[11] = '{5'b00010, 4'd9,  4'd2,  4'd3,  32'd1,        32'd2,  32'd0,        4'd0, 1'b1};
`else
    tv[11] = '{5'b01111, 4'd9,  4'd2,  4'd3,  32'd1,        32'd2,  32'd0,        4'd0, 1'b1};
`endif

    // reset state
    #2;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_count", 32'(instr_count), 32'd0);
    check("reset_strobes", 32'({PCout, MARin, Read, done, err, Yin}), 32'd0);
    @(negedge Clock);
    clear = 1'b1;

    // table-driven vectors
    for (int i = 0; i < 12; i++) begin
      preload(tv[i].rb, tv[i].vb, tv[i].rc, tv[i].vc);
      old_ra = rf[tv[i].ra];
      pc0 = pc_m;
      mem[pc_m[3:0]] = enc(tv[i].opc, tv[i].ra, tv[i].rb, tv[i].rc);
      run(1, i % 3);
      @(negedge Clock);
      #1;
      $display("vec %0d: opc=%b ra=%0d rb=%0d rc=%0d err=%0d done=%0d R[ra]=0x%0h count=%0d",
               i, tv[i].opc, tv[i].ra, tv[i].rb, tv[i].rc, n_err, n_done, rf[tv[i].ra], instr_count);
      check("busy_after", 32'(busy), 32'd0);
      check("err_pulses", n_err, 32'(tv[i].bad));
      check("done_pulses", n_done, 32'(!tv[i].bad));
      check("read_cycles", n_read, i % 3 + 1);
      check("pcin_cycles", n_pcin, 32'd1);
      check("pc_advance", pc_m, pc0 + 32'd1);
      check("invariants", n_viol, 32'd0);
      if (!tv[i].bad) begin
        exp_count++;
        check("rout_t3", 32'(rout_t3), 32'h1 << tv[i].rb);
        check("rout_t4", 32'(rout_t4), 32'h1 << tv[i].rc);
        check("operation_t4", 32'(op_t4), 32'(tv[i].op));
        check("rin_t5", 32'(rin_t5), 32'h1 << tv[i].ra);
        check("result", rf[tv[i].ra], tv[i].res);
      end else begin
        check("rout_illegal", 32'(rout_t3), 32'd0);
        check("rin_illegal", 32'(rin_t5), 32'd0);
        check("reg_kept", rf[tv[i].ra], old_ra);
      end
      check("instr_count", 32'(instr_count), exp_count);
    end

    // mem_ready held low 3 cycles in T1
    preload(4'd2, 32'd40, 4'd3, 32'd2);
    pc0 = pc_m;
    mem[pc_m[3:0]] = enc(5'b00011, 4'd5, 4'd2, 4'd3);
    run(1, 3);
    @(negedge Clock);
    exp_count++;
    $display("stall: read=%0d pcin=%0d pc=%0d R5=0x%0h", n_read, n_pcin, pc_m, rf[5]);
    check("stall_read", n_read, 32'd4);
    check("stall_pcin", n_pcin, 32'd1);
    check("stall_pc", pc_m, pc0 + 32'd1);
    check("stall_result", rf[5], 32'd42);

    // back-to-back: start held across two adds
    preload(4'd2, 32'd7, 4'd3, 32'd8);
    pc0 = pc_m;
    mem[pc0[3:0]] = enc(5'b00011, 4'd6, 4'd2, 4'd3);
    mem[pc0[3:0] + 4'd1] = enc(5'b00011, 4'd7, 4'd3, 4'd3);
    run(2, 0);
    @(negedge Clock);
    exp_count += 2;
    $display("b2b: done=%0d t5->t0=%0d R6=0x%0h R7=0x%0h count=%0d", n_done, n_b2b, rf[6], rf[7], instr_count);
    check("b2b_done", n_done, 32'd2);
    check("b2b_direct", n_b2b, 32'd1);
    check("b2b_r6", rf[6], 32'd15);
    check("b2b_r7", rf[7], 32'd16);
    check("b2b_count", 32'(instr_count), exp_count);
    check("b2b_pc", pc_m, pc0 + 32'd2);

`ifdef ALU_SEQ_MULDIV_EN
    // mul: 0x10000 * 0x10000 = 0x1_0000_0000
    preload(4'd2, 32'h10000, 4'd3, 32'h10000);
    mem[pc_m[3:0]] = enc(5'b01111, 4'd1, 4'd2, 4'd3);
    run(1, 0);
    @(negedge Clock);
    exp_count++;
    $display("mul: LO=0x%0h HI=0x%0h lo_str=%0d hi_str=%0d done=%0d", lo_m, hi_m, n_lo, n_hi, n_done);
    check("mul_op", 32'(op_t4), 32'h8);
    check("mul_lo", lo_m, 32'h0);
    check("mul_hi", hi_m, 32'h1);
    check("mul_loin", n_lo, 32'd1);
    check("mul_hiin", n_hi, 32'd1);
    check("mul_done_t6", n_done_hi, 32'd1);
    check("mul_done", n_done, 32'd1);
    check("mul_no_rin", 32'(rin_t5), 32'd0);
    check("mul_count", 32'(instr_count), exp_count);
    // div: 100 / 7 -> LO=14, HI=2
    preload(4'd2, 32'd100, 4'd3, 32'd7);
    mem[pc_m[3:0]] = enc(5'b10000, 4'd1, 4'd2, 4'd3);
    run(1, 0);
    @(negedge Clock);
    exp_count++;
    $display("div: LO=0x%0h HI=0x%0h", lo_m, hi_m);
    check("div_op", 32'(op_t4), 32'h9);
    check("div_lo", lo_m, 32'd14);
    check("div_hi", hi_m, 32'd2);
`endif

    // clear asserted during T4
    preload(4'd2, 32'd1, 4'd3, 32'd1);
    mem[pc_m[3:0]] = enc(5'b00011, 4'd8, 4'd2, 4'd3);
    mem_ready = 1'b1;
    start = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge Clock);
      start = 1'b0;
      #1;
      if (Zin_low && !IncPC) hit = 1'b1;
    end
    check("reached_t4", 32'(hit), 32'd1);
    clear = 1'b0;
    #1;
    $display("clear in T4: busy=%0d Rout=0x%0h op=%0d count=%0d", busy, Rout, operation, instr_count);
    check("clr_strobes", 32'({PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin,
                               Yin, IncPC, Read, Zin_low, Zin_high, HIin, LOin, busy, done, err}), 32'd0);
    check("clr_rout", 32'(Rout), 32'd0);
    check("clr_rin", 32'(Rin), 32'd0);
    check("clr_operation", 32'(operation), 32'd0);
    check("clr_count", 32'(instr_count), 32'd0);
    exp_count = 0;
    @(negedge Clock);
    clear = 1'b1;
    #1;
    check("post_clr_idle", 32'(busy), 32'd0);
    check("post_clr_count", 32'(instr_count), 32'd0);
    // first start after release is taken on the next edge
    mem[pc_m[3:0]] = enc(5'b00011, 4'd8, 4'd2, 4'd3);
    start = 1'b1;
    @(posedge Clock);
    #1;
    check("first_start_t0", 32'(PCout), 32'd1);
    hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge Clock);
      start = 1'b0;
      #1;
      if (done) hit = 1'b1;
    end
    @(negedge Clock);
    exp_count++;
    $display("after clear: R8=0x%0h count=%0d", rf[8], instr_count);
    check("post_clr_done", 32'(hit), 32'd1);
    check("post_clr_result", rf[8], 32'd2);
    check("post_clr_count1", 32'(instr_count), exp_count);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
